// File: rtl/vga_scan_timer.sv
// VGA raster timing generator: pixel-rate scan counters, sync decode, and a registered,
// blanked colour/sync output stage that lags the scan coordinates by exactly one pixel.
module vga_scan_timer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] Red,
    input  logic [7:0] Green,
    input  logic [7:0] Blue,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pix_ce,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       blank_n,
    output logic       frame_tick
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div;
    logic [9:0]       hc;
    logic [9:0]       vc;
    logic             active;
    logic             hs_raw;
    logic             vs_raw;

    assign DrawX = hc;
    assign DrawY = vc;

    always_comb begin
        active = (hc < H_ACT) && (vc < V_ACT);
        hs_raw = !((hc >= HS_FIRST) && (hc <= HS_LAST));
        vs_raw = !((vc >= VS_FIRST) && (vc <= VS_LAST));
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            div        <= '0;
            pix_ce     <= 1'b0;
            hc         <= '0;
            vc         <= '0;
            VGA_R      <= '0;
            VGA_G      <= '0;
            VGA_B      <= '0;
            VGA_HS     <= 1'b1;
            VGA_VS     <= 1'b1;
            blank_n    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (div == DIV_LAST) begin
                div    <= '0;
                pix_ce <= 1'b1;
            end else begin
                div    <= div + 1'b1;
                pix_ce <= 1'b0;
            end

            // Colour is captured on the same edge that moves the coordinate on, so the
            // mapper's combinational answer for (hc, vc) lands together with its syncs.
            if (pix_ce) begin
                VGA_R   <= active ? Red   : 8'h00;
                VGA_G   <= active ? Green : 8'h00;
                VGA_B   <= active ? Blue  : 8'h00;
                VGA_HS  <= hs_raw;
                VGA_VS  <= vs_raw;
                blank_n <= active;

                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
                    frame_tick <= (vc == V_ACT_LAST);
                end else begin
                    hc <= hc + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_timer.sv
// Bench for vga_scan_timer: default horizontal timing with a shortened frame, checked
// cycle by cycle against an arithmetic model of the scan plus a queue of expected pixels.
module tb_vga_scan_timer;
    localparam int HA = 640, HF = 16, HSW = 96, HB = 48;
    localparam int VA = 4, VF = 1, VSW = 2, VB = 2;
    localparam int D  = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT * D;
    localparam logic [26:0] RST_VEC = {1'b0, 24'h000000, 1'b1, 1'b1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] red, green, blue;
    logic [9:0] draw_x, draw_y;
    logic       pix_ce;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, blank_n, frame_tick;
    int         mode;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int gcyc = 0;
    int m_pce = 0, m_hc = 0, m_vc = 0, m_ft = 0;
    int ticks = 0, last_tick = 0, tick_valid = 0;
    int vs_cnt = 0, hs_run = 0;
    logic [26:0] exp_q[$];
    logic [26:0] cur_exp = RST_VEC;

    always #10 clk = ~clk;

    function automatic logic [23:0] mapper(int m, int x, int y);
        logic [23:0] c;
        if (m == 0) begin
            c = 24'hAB5501;
        end else begin
            c[23:16] = x[7:0];
            c[15:8]  = x[9:2] ^ y[7:0];
            c[7:0]   = ~x[7:0];
        end
        return c;
    endfunction

    assign {red, green, blue} = mapper(mode, int'(draw_x), int'(draw_y));

    vga_scan_timer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .CLK_DIV(D)
    ) dut (
        .Clk(clk), .Reset_n(rst_n),
        .Red(red), .Green(green), .Blue(blue),
        .DrawX(draw_x), .DrawY(draw_y), .pix_ce(pix_ce),
        .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
        .VGA_HS(vga_hs), .VGA_VS(vga_vs),
        .blank_n(blank_n), .frame_tick(frame_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, gcyc);
        end
    endtask

    // Scan position is derived from the cycle count since the last reset edge:
    // pix_ce is high on cycles D, 2D, ... and each such cycle advances the pixel index.
    task automatic model_eval();
        int n, p;
        m_pce = (cyc >= D && cyc % D == 0) ? 1 : 0;
        n = (cyc >= 1) ? (cyc - 1) / D : 0;
        m_hc = n % HT;
        m_vc = (n / HT) % VT;
        m_ft = 0;
        if (cyc - 1 >= D && (cyc - 1) % D == 0) begin
            p = n - 1;
            if (p % HT == HT - 1 && (p / HT) % VT == VA - 1) m_ft = 1;
        end
    endtask

    function automatic logic [26:0] exp_out(int hc, int vc, int m);
        logic        act, hs, vs;
        logic [23:0] col;
        act = (hc < HA) && (vc < VA);
        hs  = !((hc >= HA + HF) && (hc < HA + HF + HSW));
        vs  = !((vc >= VA + VF) && (vc < VA + VF + VSW));
        col = act ? mapper(m, hc, vc) : 24'h000000;
        return {act, col, hs, vs};
    endfunction

    task automatic tick();
        int prev_pce;
        logic [26:0] obs;
        @(negedge clk);
        if (m_pce == 1) exp_q.push_back(exp_out(m_hc, m_vc, mode));
        prev_pce = m_pce;
        @(posedge clk);
        #1;
        gcyc++;
        if (!rst_n) begin
            cyc = 0;
            exp_q.delete();
            cur_exp = RST_VEC;
            tick_valid = 0;
            vs_cnt = 0;
            hs_run = 0;
        end else begin
            cyc++;
            if (prev_pce == 1) begin
                if (exp_q.size() == 0) chk("queue_underflow", 32'(exp_q.size()), 32'd1);
                else cur_exp = exp_q.pop_front();
            end
        end
        model_eval();
        chk("pix_ce", 32'(pix_ce), 32'(m_pce));
        chk("draw_x", 32'(draw_x), 32'(m_hc));
        chk("draw_y", 32'(draw_y), 32'(m_vc));
        chk("frame_tick", 32'(frame_tick), 32'(m_ft));
        obs = {blank_n, vga_r, vga_g, vga_b, vga_hs, vga_vs};
        chk("video_out", 32'(obs), 32'(cur_exp));

        if (vga_vs === 1'b0) vs_cnt++;
        if (frame_tick === 1'b1) begin
            if (tick_valid == 1) begin
                chk("tick_period", 32'(gcyc - last_tick), 32'(FRAME));
                chk("vs_low_cycles", 32'(vs_cnt), 32'(VSW * HT * D));
            end
            tick_valid = 1;
            last_tick = gcyc;
            vs_cnt = 0;
            ticks++;
        end
        if (vga_hs === 1'b0) begin
            hs_run++;
        end else begin
            if (hs_run > 0) chk("hs_width", 32'(hs_run), 32'(HSW * D));
            hs_run = 0;
        end
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        mode  = 0;

        repeat (5) tick();
        chk("rst_draw_x", 32'(draw_x), 32'd0);
        chk("rst_draw_y", 32'(draw_y), 32'd0);
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("rst_syncs", 32'({vga_hs, vga_vs}), 32'd3);
        chk("rst_blank_n", 32'(blank_n), 32'd0);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        chk("rst_pix_ce", 32'(pix_ce), 32'd0);

        // Constant colour for the first frame, coordinate-dependent colour afterwards.
        rst_n = 1'b1;
        repeat (10000) tick();
        mode = 1;
        repeat (11000) tick();
        chk("ticks_two_frames", 32'(ticks), 32'd2);

        guard = 0;
        while (!(m_hc == 300 && m_vc == 2) && guard < FRAME) begin
            tick();
            guard++;
        end
        chk("reach_300_2", 32'(guard < FRAME), 32'd1);

        rst_n = 1'b0;
        tick();
        chk("midrst_draw", 32'({draw_x, draw_y}), 32'd0);
        chk("midrst_video", 32'({blank_n, vga_r, vga_g, vga_b, vga_hs, vga_vs}), 32'(RST_VEC));
        chk("midrst_pix_ce", 32'(pix_ce), 32'd0);
        chk("midrst_frame_tick", 32'(frame_tick), 32'd0);

        rst_n = 1'b1;
        ticks = 0;
        repeat (FRAME + 8000) tick();
        chk("ticks_after_reset", 32'(ticks), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_scan_timer.md
Name: vga_scan_timer

Overview:
- Raster timing generator for the 640x480 @ 60 Hz VGA display path. Sources the DrawX/DrawY scan coordinates that the colour mappers consume.
- Accepts the mapper's combinational Red/Green/Blue back in the same pixel period. Registers it, blanks it outside the active area, and drives DAC colour and sync pins that are aligned to each other.
- Emits a one-Clk frame_tick at the start of vertical blanking. Game logic (ball/sprite position updates) uses it as its per-frame strobe.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, Clk cycles per pixel; must be >=1

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  synchronous active-low reset
- Red  in  8  mapper red for the current DrawX/DrawY
- Green  in  8  mapper green
- Blue  in  8  mapper blue
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- pix_ce  out  1  one-Clk pixel enable, high every CLK_DIV cycles
- VGA_R  out  8  registered, blanked red
- VGA_G  out  8  registered, blanked green
- VGA_B  out  8  registered, blanked blue
- VGA_HS  out  1  hsync, active low
- VGA_VS  out  1  vsync, active low
- blank_n  out  1  high when VGA_R/G/B carry active video
- frame_tick  out  1  one-Clk pulse at the start of vertical blanking

Behaviour:
- Definitions: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL likewise (default 525). Both must be <=1024. All state updates on the rising edge of Clk.
- Reset: Reset_n sampled low at an edge loads the following next cycle, overriding all other activity including mid-frame:
  - divider=0, hc=0, vc=0, pix_ce=0
  - VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, blank_n=0, frame_tick=0
- Divider: counts 0..CLK_DIV-1 and wraps. pix_ce is registered high for the single cycle after the divider reaches CLK_DIV-1. With CLK_DIV=1, pix_ce is constantly high once out of reset.
- Counters (advance only in cycles where pix_ce=1):
  - hc increments; at H_TOTAL-1 it wraps to 0 and vc advances.
  - vc wraps from V_TOTAL-1 to 0 when hc wraps.
  - DrawX=hc and DrawY=vc, driven directly from the registers. They hold stable for CLK_DIV cycles.
- Decode, evaluated on the current hc/vc:
  - active = (hc<H_ACTIVE) && (vc<V_ACTIVE)
  - hs_raw low for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (default 656..751)
  - vs_raw low for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (default 490..491)
- Output stage (registered in cycles where pix_ce=1, same edge as the counter advance):
  - VGA_R/G/B = active ? Red/Green/Blue : 0
  - VGA_HS = hs_raw, VGA_VS = vs_raw, blank_n = active
  - Net latency is exactly one pixel period from a coordinate to its colour/sync. All outputs change on the same Clk edge.
- frame_tick: high for exactly one Clk cycle, on the cycle after the pix_ce edge where vc transitions V_ACTIVE-1 -> V_ACTIVE. Exactly one pulse per frame; never asserted during or immediately after reset.
- Input assumption: Red/Green/Blue are purely combinational in DrawX/DrawY and must settle within one Clk. No handshake.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV Clk cycles (default 840000).

Test Plan:
- Reset: Reset_n low for 5 Clk -> DrawX=0, DrawY=0, VGA_HS=1, VGA_VS=1, blank_n=0, VGA_R/G/B=0, frame_tick=0, pix_ce=0.
- Scan rate: release reset -> pix_ce pulses every 2 Clk. DrawX steps 0,1,2... every 2 Clk. At DrawX 799 -> 0, DrawY goes 0 -> 1. DrawY 524 -> 0 coincides with DrawX 799 -> 0.
- Hsync: VGA_HS first goes low on the pix_ce edge after hc=656 is presented, stays low 96 pixels (192 Clk), then high. Same pattern every line.
- Vsync/frame: VGA_VS low for exactly 1600 pixel periods per frame. Consecutive frame_tick pulses are exactly 840000 Clk apart, each one Clk wide, following the update DrawY 479 -> 480.
- Colour gating: hold Red=8'hAB, Green=8'h55, Blue=8'h01 -> outputs AB/55/01 with blank_n=1 for coordinates in 0..639 x 0..479, observed one pixel later. Outputs are 00/00/00 with blank_n=0 when hc>=640 or vc>=480. Check the edge at hc=639 -> 640.
- Mid-frame reset: assert Reset_n low when DrawX=300, DrawY=200 -> next Clk shows all reset values. After release, the counters restart from (0,0) with the normal pix_ce cadence and a full frame follows.
